sifh_peak_window: RTL and testbench
===================================

// Module: sifh_peak_window
// PURPOSE
// - Coarse-pass peak finder and window generator for two-pass SiFH histogramming.
// - Pass 0 (his_num=0): accumulates coarse NB-bit bin hits; on frame end, scans for the peak bin.
// - Drives th_minus / th_positive / delta / his_num to the data filter, which then runs fine pass 1.
// PARAMETERS
// - NP   `Np (16)  timestamp width (rough data)
// - NB   `Nb (4)   coarse bin index width; 2^NB bins
// - CW   12        per-bin hit counter width (saturating)
// PORTS
// - clk          in   1    system clock
// - rst_n        in   1    async active-low reset
// - start        in   1    pulse: clear histogram, begin coarse pass
// - bin_valid    in   1    coarse hit strobe
// - bin_idx      in   NB   coarse bin of hit (top NB bits of rough data)
// - frame_done   in   1    pulse: coarse pass finished
// - fine_done    in   1    pulse: fine pass finished
// - win_valid    out  1    window outputs valid
// - win_ready    in   1    consumer accepts window
// - th_minus     out  NP   window lower bound (inclusive)
// - th_positive  out  NP   window upper bound (inclusive)
// - delta        out  NP   offset subtracted in fine pass (= th_minus)
// - his_num      out  1    0 = coarse pass, 1 = fine pass
// - peak_hit     out  1    1 = nonzero peak found in last scan
// - busy         out  1    high in any state but IDLE
// BEHAVIOUR
// - FSM IDLE->ACCUM->SCAN->CALC->PRESENT->FINE->IDLE. Reset: IDLE; all outputs 0; counters 0.
// - IDLE: start -> clear all 2^NB counters in same edge, go ACCUM.
// - ACCUM: bin_valid increments cnt[bin_idx]; saturates at 2^CW-1. frame_done -> SCAN;
//   bin_valid coincident with frame_done is counted. bin_valid outside ACCUM ignored.
// - SCAN: one bin/cycle, index 0..2^NB-1 (2^NB cycles); strict > compare, ties keep lowest index.
// - CALC (1 cycle): W=2^(NP-NB); lo=peak*W; hi=lo+W-1; delta=lo; peak_hit=(max!=0).
//   Zero-hit frame: peak_hit=0, th_minus=0, th_positive=all ones, delta=0 (full-range pass).
// - PRESENT: win_valid=1, outputs stable until win_valid&&win_ready; then FINE.
// - FINE: his_num=1, win_valid=0, window held; fine_done -> IDLE (his_num=0, window retained).
// - start in FINE: abort fine pass, clear, go ACCUM. start in ACCUM..PRESENT: ignored.
// - frame_done outside ACCUM, fine_done outside FINE: ignored.
// - Latency frame_done -> win_valid: 2^NB+2 cycles.
// - rst_n low mid-operation: immediate IDLE, counters and outputs 0; no partial window.
// CONFIGURATION
// - SIFH_GUARD_BIN_EN defined: window widened one coarse bin each side, clamped:
//   lo=max(peak-1,0)*W, hi=min((peak+2)*W-1, 2^NP-1); delta=lo. Catches peaks straddling a bin edge.
// - Undefined: window is exactly the peak bin as above.
// STRUCTURE
// - Shared include parametersSiFH.vh: `Np, `Nb, counter width, FSM state encodings.
// - Sub-module sifh_max_finder: sequential argmax over counter array (index in, max/argmax out).
// - Top holds counter array, FSM, window arithmetic and output registers.
// TESTING
// - NP=16,NB=4: start, 5 hits bin 3, 9 hits bin 7, frame_done -> after 18 cycles win_valid,
//   th_minus=0x7000, th_positive=0x7FFF, delta=0x7000, peak_hit=1.
// - Tie: 4 hits bins 2 and 11 -> peak bin 2, th_minus=0x2000.
// - No hits, frame_done -> peak_hit=0, th_minus=0, th_positive=0xFFFF, delta=0.
// - win_ready low 10 cycles -> outputs stable, his_num=0; ready high -> next cycle his_num=1.
// - CW=4, 20 hits bin 5 -> counter holds 15; peak bin 5 still selected.
// - GUARD_EN, peak bin 0 -> th_minus=0, th_positive=0x1FFF; peak bin 15 -> 0xE000..0xFFFF.
// - rst_n low during SCAN -> busy=0, win_valid=0, his_num=0; new start counts from zero.

Source files
------------

// File: rtl/sifh_peak_window_pkg.sv
// Shared widths and FSM encoding for the SiFH coarse peak finder / window generator.
package sifh_peak_window_pkg;

    localparam int SIFH_NP = 16;
    localparam int SIFH_NB = 4;
    localparam int SIFH_CW = 12;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCUM   = 3'd1,
        ST_SCAN    = 3'd2,
        ST_CALC    = 3'd3,
        ST_PRESENT = 3'd4,
        ST_FINE    = 3'd5
    } sifh_state_t;

endpackage

// File: rtl/sifh_peak_window_max_finder.sv
// Purpose: sequential argmax over a stream of (index, value) pairs; index 0 restarts the search.
// Latency: result for the last pair is valid one cycle after it is presented.
// Backpressure: none; consumes one pair per enabled cycle.
module sifh_max_finder #(
    parameter int NB = 4,
    parameter int CW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [NB-1:0] idx,
    input  logic [CW-1:0] val,
    output logic [CW-1:0] max_val,
    output logic [NB-1:0] max_idx
);

    // Strict greater-than keeps the lowest index on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_val <= '0;
            max_idx <= '0;
        end else if (en) begin
            if (idx == '0 || val > max_val) begin
                max_val <= val;
                max_idx <= idx;
            end
        end
    end

endmodule

// File: rtl/sifh_peak_window.sv
// Purpose: coarse-pass histogram, peak scan and fine-pass window generation (SIFH_GUARD_BIN_EN widens window by one bin each side).
// Latency: frame_done to win_valid is 2^NB+2 cycles.
// Backpressure: window held with win_valid high until win_ready; fine pass starts the cycle after.
module sifh_peak_window
    import sifh_peak_window_pkg::*;
#(
    parameter int NP = SIFH_NP,
    parameter int NB = SIFH_NB,
    parameter int CW = SIFH_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          bin_valid,
    input  logic [NB-1:0] bin_idx,
    input  logic          frame_done,
    input  logic          fine_done,
    output logic          win_valid,
    input  logic          win_ready,
    output logic [NP-1:0] th_minus,
    output logic [NP-1:0] th_positive,
    output logic [NP-1:0] delta,
    output logic          his_num,
    output logic          peak_hit,
    output logic          busy
);

    localparam int NBINS = 1 << NB;
    localparam int SH    = NP - NB;
    localparam logic [NB-1:0] BIN_ONE = NB'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    sifh_state_t state_q, state_d;

    logic [CW-1:0] cnt [NBINS];
    logic [NB-1:0] scan_idx;
    logic          scan_last;
    logic          clr;
    logic [CW-1:0] max_val;
    logic [NB-1:0] max_idx;
    logic [NB-1:0] lo_bin, hi_bin;
    logic [NP-1:0] lo_c, hi_c;

    assign scan_last = (scan_idx == '1);
    assign clr       = start && (state_q == ST_IDLE || state_q == ST_FINE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start)      state_d = ST_ACCUM;
            ST_ACCUM:   if (frame_done) state_d = ST_SCAN;
            ST_SCAN:    if (scan_last)  state_d = ST_CALC;
            ST_CALC:                    state_d = ST_PRESENT;
            ST_PRESENT: if (win_ready)  state_d = ST_FINE;
            ST_FINE: begin
                if (start)          state_d = ST_ACCUM;
                else if (fine_done) state_d = ST_IDLE;
            end
            default:                    state_d = ST_IDLE;
        endcase
    end

    // A hit arriving with frame_done still lands because ACCUM is the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NBINS; i++) cnt[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < NBINS; i++) cnt[i] <= '0;
        end else if (state_q == ST_ACCUM && bin_valid && cnt[bin_idx] != '1) begin
            cnt[bin_idx] <= cnt[bin_idx] + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 scan_idx <= '0;
        else if (state_q != ST_SCAN) scan_idx <= '0;
        else                        scan_idx <= scan_idx + BIN_ONE;
    end

    sifh_max_finder #(
        .NB (NB),
        .CW (CW)
    ) u_max (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (state_q == ST_SCAN),
        .idx     (scan_idx),
        .val     (cnt[scan_idx]),
        .max_val (max_val),
        .max_idx (max_idx)
    );

    // Window bounds are whole coarse bins, so they are just the bin index with zero/one fill.
    always_comb begin
`ifdef SIFH_GUARD_BIN_EN
        lo_bin = (max_idx == '0) ? '0 : max_idx - BIN_ONE;
        hi_bin = (max_idx == '1) ? max_idx : max_idx + BIN_ONE;
`else
        lo_bin = max_idx;
        hi_bin = max_idx;
`endif
        lo_c = {lo_bin, {SH{1'b0}}};
        hi_c = {hi_bin, {SH{1'b1}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            th_minus    <= '0;
            th_positive <= '0;
            delta       <= '0;
            peak_hit    <= 1'b0;
        end else if (state_q == ST_CALC) begin
            if (max_val == '0) begin
                th_minus    <= '0;
                th_positive <= '1;
                delta       <= '0;
                peak_hit    <= 1'b0;
            end else begin
                th_minus    <= lo_c;
                th_positive <= hi_c;
                delta       <= lo_c;
                peak_hit    <= 1'b1;
            end
        end
    end

    assign win_valid = (state_q == ST_PRESENT);
    assign his_num   = (state_q == ST_FINE);
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sifh_peak_window.sv
// Directed bench for sifh_peak_window; a second CW=4 instance exposes counter saturation.
module tb_sifh_peak_window;

    logic        clk = 1'b0;
    logic        rst_n, start, bin_valid, frame_done, fine_done, win_ready;
    logic [3:0]  bin_idx;
    logic        win_valid, his_num, peak_hit, busy;
    logic [15:0] th_minus, th_positive, delta;
    logic        s_win_valid, s_his_num, s_peak_hit, s_busy;
    logic [15:0] s_th_minus, s_th_positive, s_delta;
    int          checks = 0;
    int          passes = 0;

    always #5 clk = ~clk;

    sifh_peak_window #(.NP(16), .NB(4), .CW(12)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_valid(bin_valid), .bin_idx(bin_idx),
        .frame_done(frame_done), .fine_done(fine_done), .win_valid(win_valid), .win_ready(win_ready),
        .th_minus(th_minus), .th_positive(th_positive), .delta(delta), .his_num(his_num),
        .peak_hit(peak_hit), .busy(busy)
    );

    sifh_peak_window #(.NP(16), .NB(4), .CW(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_valid(bin_valid), .bin_idx(bin_idx),
        .frame_done(frame_done), .fine_done(fine_done), .win_valid(s_win_valid), .win_ready(win_ready),
        .th_minus(s_th_minus), .th_positive(s_th_positive), .delta(s_delta), .his_num(s_his_num),
        .peak_hit(s_peak_hit), .busy(s_busy)
    );

    function automatic logic [15:0] exp_lo(input int b);
`ifdef SIFH_GUARD_BIN_EN
        return 16'(((b == 0) ? 0 : b - 1) * 4096);
`else
        return 16'(b * 4096);
`endif
    endfunction

    function automatic logic [15:0] exp_hi(input int b);
`ifdef SIFH_GUARD_BIN_EN
        return (b == 15) ? 16'hFFFF : 16'((b + 2) * 4096 - 1);
`else
        return 16'(b * 4096 + 4095);
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1; tick; start = 1'b0;
    endtask

    task automatic hits(input int b, input int n);
        for (int i = 0; i < n; i++) begin
            bin_valid = 1'b1; bin_idx = 4'(b); tick;
        end
        bin_valid = 1'b0;
    endtask

    // Counts edges from the one sampling frame_done up to the first cycle with win_valid.
    task automatic finish_frame(output int lat);
        frame_done = 1'b1; tick; frame_done = 1'b0; lat = 1;
        while (!win_valid && lat < 100) begin
            tick; lat++;
        end
    endtask

    task automatic accept;
        win_ready = 1'b1; tick; win_ready = 1'b0;
    endtask

    task automatic fine_end;
        fine_done = 1'b1; tick; fine_done = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 0; bin_valid = 0; bin_idx = 0; frame_done = 0; fine_done = 0; win_ready = 0;
        repeat (3) tick;
        checks++; if ({busy, win_valid, his_num, peak_hit} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {busy, win_valid, his_num, peak_hit}); else passes++;
        checks++; if ({th_minus, th_positive, delta} !== 48'h0) $display("FAIL reset_window: got %h want 0", {th_minus, th_positive, delta}); else passes++;
        rst_n = 1'b1; tick;
    endtask

    task automatic test_basic;
        int lat;
        logic stable;
        pulse_start;
        checks++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else passes++;
        hits(3, 5); hits(7, 9);
        finish_frame(lat);
        checks++; if (lat !== 18) $display("FAIL basic_latency: got %0d want 18", lat); else passes++;
        checks++; if (th_minus !== exp_lo(7)) $display("FAIL basic_lo: got %h want %h", th_minus, exp_lo(7)); else passes++;
        checks++; if (th_positive !== exp_hi(7)) $display("FAIL basic_hi: got %h want %h", th_positive, exp_hi(7)); else passes++;
        checks++; if (delta !== exp_lo(7)) $display("FAIL basic_delta: got %h want %h", delta, exp_lo(7)); else passes++;
        checks++; if (peak_hit !== 1'b1) $display("FAIL basic_peak_hit: got %b want 1", peak_hit); else passes++;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (!(win_valid === 1'b1 && his_num === 1'b0 && th_minus === exp_lo(7) && th_positive === exp_hi(7))) stable = 1'b0;
        end
        checks++; if (stable !== 1'b1) $display("FAIL stall_stable: got %b want 1", stable); else passes++;
        accept;
        checks++; if ({his_num, win_valid} !== 2'b10) $display("FAIL accept_fine: got %b want 10", {his_num, win_valid}); else passes++;
        frame_done = 1'b1; tick; frame_done = 1'b0;
        checks++; if (his_num !== 1'b1) $display("FAIL fine_ignores_frame_done: got %b want 1", his_num); else passes++;
        fine_end;
        checks++; if ({busy, his_num} !== 2'b00) $display("FAIL fine_done_idle: got %b want 00", {busy, his_num}); else passes++;
        checks++; if (th_minus !== exp_lo(7) || peak_hit !== 1'b1) $display("FAIL window_retained: got %h/%b want %h/1", th_minus, peak_hit, exp_lo(7)); else passes++;
    endtask

    task automatic test_tie;
        int lat;
        pulse_start; hits(2, 4); hits(11, 4);
        finish_frame(lat);
        checks++; if (th_minus !== exp_lo(2)) $display("FAIL tie_lo: got %h want %h", th_minus, exp_lo(2)); else passes++;
        checks++; if (th_positive !== exp_hi(2)) $display("FAIL tie_hi: got %h want %h", th_positive, exp_hi(2)); else passes++;
        accept; fine_end;
    endtask

    task automatic test_coincident;
        int lat;
        pulse_start; hits(2, 4); hits(11, 4);
        bin_valid = 1'b1; bin_idx = 4'd11;
        frame_done = 1'b1; tick; frame_done = 1'b0; bin_valid = 1'b0; lat = 1;
        while (!win_valid && lat < 100) begin
            tick; lat++;
        end
        checks++; if (th_minus !== exp_lo(11)) $display("FAIL coincident_hit: got %h want %h", th_minus, exp_lo(11)); else passes++;
        accept; fine_end;
    endtask

    task automatic test_zero;
        int lat;
        pulse_start;
        finish_frame(lat);
        checks++; if (lat !== 18) $display("FAIL zero_latency: got %0d want 18", lat); else passes++;
        checks++; if (peak_hit !== 1'b0) $display("FAIL zero_peak_hit: got %b want 0", peak_hit); else passes++;
        checks++; if ({th_minus, th_positive, delta} !== {16'h0000, 16'hFFFF, 16'h0000}) $display("FAIL zero_window: got %h want 0000ffff0000", {th_minus, th_positive, delta}); else passes++;
        accept; fine_end;
    endtask

    task automatic test_saturate;
        int lat;
        pulse_start; hits(5, 20); hits(2, 10); hits(12, 15);
        finish_frame(lat);
        checks++; if (th_minus !== exp_lo(5)) $display("FAIL sat_wide_peak: got %h want %h", th_minus, exp_lo(5)); else passes++;
        checks++; if (s_th_minus !== exp_lo(5)) $display("FAIL sat_cw4_peak: got %h want %h", s_th_minus, exp_lo(5)); else passes++;
        checks++; if (s_win_valid !== 1'b1) $display("FAIL sat_cw4_valid: got %b want 1", s_win_valid); else passes++;
        accept; fine_end;
    endtask

    task automatic test_abort;
        int lat;
        pulse_start; hits(4, 3);
        pulse_start;
        hits(1, 1);
        finish_frame(lat);
        checks++; if (th_minus !== exp_lo(4)) $display("FAIL start_in_accum_ignored: got %h want %h", th_minus, exp_lo(4)); else passes++;
        accept;
        hits(3, 2);
        pulse_start;
        checks++; if ({busy, his_num} !== 2'b10) $display("FAIL abort_to_accum: got %b want 10", {busy, his_num}); else passes++;
        hits(1, 1);
        finish_frame(lat);
        checks++; if (th_minus !== exp_lo(1)) $display("FAIL abort_cleared: got %h want %h", th_minus, exp_lo(1)); else passes++;
        accept; fine_end;
    endtask

    task automatic test_edge_bins;
        int lat;
        pulse_start; hits(0, 2);
        finish_frame(lat);
        checks++; if ({th_minus, th_positive} !== {exp_lo(0), exp_hi(0)}) $display("FAIL bin0_window: got %h want %h", {th_minus, th_positive}, {exp_lo(0), exp_hi(0)}); else passes++;
        accept; fine_end;
        pulse_start; hits(15, 1);
        finish_frame(lat);
        checks++; if ({th_minus, th_positive} !== {exp_lo(15), exp_hi(15)}) $display("FAIL bin15_window: got %h want %h", {th_minus, th_positive}, {exp_lo(15), exp_hi(15)}); else passes++;
        checks++; if (delta !== exp_lo(15)) $display("FAIL bin15_delta: got %h want %h", delta, exp_lo(15)); else passes++;
        accept; fine_end;
    endtask

    task automatic test_reset_scan;
        int lat;
        pulse_start; hits(6, 3);
        frame_done = 1'b1; tick; frame_done = 1'b0;
        repeat (5) tick;
        rst_n = 1'b0; #2;
        checks++; if ({busy, win_valid, his_num, peak_hit} !== 4'b0) $display("FAIL scan_reset_flags: got %b want 0000", {busy, win_valid, his_num, peak_hit}); else passes++;
        checks++; if ({th_minus, th_positive} !== 32'h0) $display("FAIL scan_reset_window: got %h want 0", {th_minus, th_positive}); else passes++;
        tick; rst_n = 1'b1; tick;
        pulse_start; hits(9, 1);
        finish_frame(lat);
        checks++; if (lat !== 18 || th_minus !== exp_lo(9)) $display("FAIL after_reset_run: got %0d/%h want 18/%h", lat, th_minus, exp_lo(9)); else passes++;
        accept; fine_end;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_tie;
        test_coincident;
        test_zero;
        test_saturate;
        test_abort;
        test_edge_bins;
        test_reset_scan;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
